stop_it_ctrl: RTL and testbench

//   Game sequencer for the "Stop It" datapath. On a start press it steps the 5-bit LFSR once.
//   It latches the new value as the target, then counts a 5-bit display value down at a fixed tick rate.
//   A stop press is judged as win or lose, the result is held for a fixed time, and the block returns to idle.

---
 rtl/stop_it_ctrl_if.sv | 26 ++
 rtl/stop_it_ctrl.sv | 105 ++++++++++
 tb/tb_stop_it_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/stop_it_ctrl_if.sv
// Signal bundle between the Stop It sequencer and its button/LFSR/display side.
// The master drives buttons and LFSR value; the slave is the sequencer.
interface stop_it_ctrl_if;
  logic       go_i;
  logic       stop_i;
  logic [4:0] rand_i;
  logic       next_o;
  logic [4:0] target_o;
  logic [4:0] count_o;
  logic [3:0] score_o;
  logic       running_o;
  logic       win_o;
  logic       lose_o;

  modport master (
    output go_i, stop_i, rand_i,
    input  next_o, target_o, count_o, score_o,
    input  running_o, win_o, lose_o
  );

  modport slave (
    input  go_i, stop_i, rand_i,
    output next_o, target_o, count_o, score_o,
    output running_o, win_o, lose_o
  );
endinterface

// File: rtl/stop_it_ctrl.sv
// Stop It game sequencer: picks a target from the LFSR, counts down,
// judges the stop press and holds WIN/LOSE before returning to idle.
module stop_it_ctrl #(
  parameter int TICK_CYCLES   = 25_000_000,
  parameter int RESULT_CYCLES = 50_000_000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  stop_it_ctrl_if.slave bus
);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int RW = $clog2(RESULT_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0] RES_LAST  = RW'(RESULT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_RUN, S_WIN, S_LOSE
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    target_q, target_d;
  logic [4:0]    count_q, count_d;
  logic [3:0]    score_q, score_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [RW-1:0] res_q, res_d;
  logic          next;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    score_d  = score_q;
    tick_d   = tick_q;
    res_d    = res_q;
    next     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.go_i) begin
          next    = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        target_d = bus.rand_i;
        count_d  = 5'd31;
        tick_d   = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // stop beats a terminal tick, so the displayed value is judged
        if (bus.stop_i) begin
          tick_d = '0;
          res_d  = '0;
          if (count_q == target_q) begin
            state_d = S_WIN;
            score_d = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
          end else begin
            state_d = S_LOSE;
            score_d = 4'd0;
          end
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          count_d = count_q - 5'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_WIN, S_LOSE: begin
        if (res_q == RES_LAST) begin
          res_d   = '0;
          state_d = S_IDLE;
        end else begin
          res_d = res_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      count_q  <= '0;
      score_q  <= '0;
      tick_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      score_q  <= score_d;
      tick_q   <= tick_d;
      res_q    <= res_d;
    end
  end

  assign bus.next_o    = next;
  assign bus.target_o  = target_q;
  assign bus.count_o   = count_q;
  assign bus.score_o   = score_q;
  assign bus.running_o = (state_q == S_RUN);
  assign bus.win_o     = (state_q == S_WIN);
  assign bus.lose_o    = (state_q == S_LOSE);
endmodule

// File: tb/tb_stop_it_ctrl.sv
// Bench for stop_it_ctrl: every change of the output snapshot is popped
// from an expected queue, together with how long the previous one lasted.
module tb_stop_it_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stop_it_ctrl_if bus ();

  stop_it_ctrl #(.TICK_CYCLES(4), .RESULT_CYCLES(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic       nx;
    logic [4:0] tg;
    logic [4:0] ct;
    logic [3:0] sc;
    logic       run;
    logic       win;
    logic       lose;
  } snap_t;

  typedef struct {
    snap_t s;
    int    hold;
  } exp_t;

  exp_t  expq[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;

  function automatic void push(input logic nx, input int tg, input int ct,
                               input int sc, input logic r, input logic w,
                               input logic l, input int hold);
    exp_t e;
    e.s    = '{nx, 5'(tg), 5'(ct), 4'(sc), r, w, l};
    e.hold = hold;
    expq.push_back(e);
  endfunction

  // Monitor: compare on every change of the visible outputs
  initial begin
    snap_t last, cur;
    bit    first;
    int    since, n;
    exp_t  e;
    first = 1'b1;
    since = 0;
    n     = 0;
    last  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        since++;
        cur = '{bus.next_o, bus.target_o, bus.count_o, bus.score_o,
                bus.running_o, bus.win_o, bus.lose_o};
        if (first || cur != last) begin
          total++;
          n++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL snap%0d unexpected change got=%h", n, cur);
          end else begin
            e = expq.pop_front();
            if (cur != e.s || (!first && e.hold != 0 && since != e.hold)) begin
              bad++;
              $display("FAIL snap%0d got nx=%0d tg=%0d ct=%0d sc=%0d rwl=%0d%0d%0d hold=%0d need nx=%0d tg=%0d ct=%0d sc=%0d rwl=%0d%0d%0d hold=%0d",
                       n, cur.nx, cur.tg, cur.ct, cur.sc, cur.run, cur.win,
                       cur.lose, since, e.s.nx, e.s.tg, e.s.ct, e.s.sc,
                       e.s.run, e.s.win, e.s.lose, e.hold);
            end
          end
          first = 1'b0;
          since = 0;
          last  = cur;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [4:0] v);
    int n;
    n = 0;
    while (bus.count_o != v && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_count got=%0d need=%0d", bus.count_o, v);
    end
  endtask

  task automatic press_go(input logic [4:0] nr, input logic with_stop);
    bus.go_i   = 1'b1;
    bus.stop_i = with_stop;
    tick();
    bus.go_i   = 1'b0;
    bus.stop_i = 1'b0;
    bus.rand_i = nr;
  endtask

  initial begin
    int sc;
    int p;
    bus.go_i   = 1'b0;
    bus.stop_i = 1'b0;
    bus.rand_i = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    tick();

    // game 1: target 3, full lap with wrap, win on count 3
    push(1, 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 1);
    push(0, 3, 31, 0, 1, 0, 0, 1);
    for (int c = 30; c >= 0; c--) push(0, 3, c, 0, 1, 0, 0, 4);
    for (int c = 31; c >= 3; c--) push(0, 3, c, 0, 1, 0, 0, 4);
    push(0, 3, 3, 1, 0, 1, 0, 1);
    push(0, 3, 3, 1, 0, 0, 0, 8);
    press_go(5'd3, 1'b0);
    wait_cnt(5'd1);
    wait_cnt(5'd0);
    wait_cnt(5'd3);
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    tick();
    bus.go_i   = 1'b1;
    bus.stop_i = 1'b1;
    tick();
    bus.go_i   = 1'b0;
    bus.stop_i = 1'b0;
    repeat (10) tick();

    // game 2: target 7, go in RUN ignored, lose at count 10
    push(1, 3, 3, 1, 0, 0, 0, 0);
    push(0, 3, 3, 1, 0, 0, 0, 1);
    push(0, 7, 31, 1, 1, 0, 0, 1);
    for (int c = 30; c >= 10; c--) push(0, 7, c, 1, 1, 0, 0, 4);
    push(0, 7, 10, 0, 0, 0, 1, 1);
    push(0, 7, 10, 0, 0, 0, 0, 8);
    press_go(5'd7, 1'b0);
    wait_cnt(5'd20);
    bus.go_i = 1'b1;
    tick();
    bus.go_i = 1'b0;
    wait_cnt(5'd10);
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    tick();
    bus.stop_i = 1'b1;
    bus.go_i   = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    bus.go_i   = 1'b0;
    repeat (10) tick();

    // game 3: stop together with go on the terminal tick of count 5
    push(1, 7, 10, 0, 0, 0, 0, 0);
    push(0, 7, 10, 0, 0, 0, 0, 1);
    push(0, 5, 31, 0, 1, 0, 0, 1);
    for (int c = 30; c >= 5; c--) push(0, 5, c, 0, 1, 0, 0, 4);
    push(0, 5, 5, 1, 0, 1, 0, 4);
    push(0, 5, 5, 1, 0, 0, 0, 8);
    press_go(5'd5, 1'b0);
    wait_cnt(5'd5);
    repeat (3) tick();
    bus.stop_i = 1'b1;
    bus.go_i   = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    bus.go_i   = 1'b0;
    repeat (10) tick();

    // game 4: reset in the middle of RUN
    push(1, 5, 5, 1, 0, 0, 0, 0);
    push(0, 5, 5, 1, 0, 0, 0, 1);
    push(0, 9, 31, 1, 1, 0, 0, 1);
    push(0, 9, 30, 1, 1, 0, 0, 4);
    push(0, 9, 29, 1, 1, 0, 0, 4);
    push(0, 0, 0, 0, 0, 0, 0, 1);
    press_go(5'd9, 1'b0);
    wait_cnt(5'd29);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // 16 straight wins with target 31; first go has a stop alongside
    for (int k = 1; k <= 16; k++) begin
      p  = (k == 1) ? 0 : 31;
      sc = (k > 15) ? 15 : k;
      push(1, p, p, k - 1, 0, 0, 0, 0);
      push(0, p, p, k - 1, 0, 0, 0, 1);
      push(0, 31, 31, k - 1, 1, 0, 0, 1);
      push(0, 31, 31, sc, 0, 1, 0, 1);
      push(0, 31, 31, sc, 0, 0, 0, 8);
      press_go(5'd31, k == 1);
      tick();
      bus.stop_i = 1'b1;
      tick();
      bus.stop_i = 1'b0;
      repeat (10) tick();
    end

    for (int i = 0; i < 50 && expq.size() != 0; i++) tick();
    while (expq.size() != 0) begin
      void'(expq.pop_front());
      total++;
      bad++;
      $display("FAIL missing_snapshot got=none need=queued");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
